// File: rtl/data_bus_bridge_pkg.sv
// data_bus_bridge_pkg: shared types and constants for the MEM-stage bus bridge.
//   state_t       bridge FSM states
//   MASK_*        byte-lane mask encodings (bit i selects byte lane i)
//   TIMEOUT_DEF   default REQ-state wait limit when DATA_BUS_BRIDGE_TIMEOUT_EN is defined
//   lane_expand   expands a 4-bit lane mask into a 32-bit bit mask
package data_bus_bridge_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [3:0] MASK_B0 = 4'b0001;
    localparam logic [3:0] MASK_B1 = 4'b0010;
    localparam logic [3:0] MASK_B2 = 4'b0100;
    localparam logic [3:0] MASK_B3 = 4'b1000;
    localparam logic [3:0] MASK_H0 = 4'b0011;
    localparam logic [3:0] MASK_H1 = 4'b1100;
    localparam logic [3:0] MASK_W  = 4'b1111;

    localparam int TIMEOUT_DEF = 64;

    function automatic logic [31:0] lane_expand(input logic [3:0] mask);
        logic [31:0] bits;
        bits = '0;
        for (int i = 0; i < 4; i++) begin
            bits[8*i +: 8] = {8{mask[i]}};
        end
        return bits;
    endfunction

endpackage

// File: rtl/data_bus_bridge_if.sv
// data_bus_bridge_if: MEM-stage request side plus system-bus side of the bridge.
//   MEM side : memCe, memWr, memRr, memAddr, wtData, w_mask, r_mask -> bridge
//              rdData, stall, err                                   <- bridge
//   Bus side : bus_req, bus_we, bus_addr, bus_wdata, bus_mask        <- bridge
//              bus_ack, bus_err, bus_rdata                           -> bridge
//   modport master : the bridge itself (it masters the bus on behalf of MEM)
//   modport slave  : the environment (MEM stage and bus target)
interface data_bus_bridge_if;

    logic        memCe;
    logic        memWr;
    logic        memRr;
    logic [31:0] memAddr;
    logic [31:0] wtData;
    logic [3:0]  w_mask;
    logic [3:0]  r_mask;
    logic [31:0] rdData;
    logic        stall;
    logic        err;

    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [3:0]  bus_mask;
    logic        bus_ack;
    logic        bus_err;
    logic [31:0] bus_rdata;

    modport master (
        input  memCe, memWr, memRr, memAddr, wtData, w_mask, r_mask,
        output rdData, stall, err,
        output bus_req, bus_we, bus_addr, bus_wdata, bus_mask,
        input  bus_ack, bus_err, bus_rdata
    );

    modport slave (
        output memCe, memWr, memRr, memAddr, wtData, w_mask, r_mask,
        input  rdData, stall, err,
        input  bus_req, bus_we, bus_addr, bus_wdata, bus_mask,
        output bus_ack, bus_err, bus_rdata
    );

endinterface

// File: rtl/data_bus_bridge_align_chk.sv
// bridge_align_chk: flags byte-lane masks that do not fit the low address bits.
//   addr_i       [1:0] low address bits
//   mask_i       [3:0] byte-lane mask
//   misaligned_o       1 when the access must not reach the bus
module bridge_align_chk
    import data_bus_bridge_pkg::*;
(
    input  logic [1:0] addr_i,
    input  logic [3:0] mask_i,
    output logic       misaligned_o
);

    always_comb begin
        misaligned_o = 1'b1;
        unique case (mask_i)
            MASK_W:                             misaligned_o = (addr_i != 2'b00);
            MASK_H0, MASK_H1:                   misaligned_o = addr_i[0];
            MASK_B0, MASK_B1, MASK_B2, MASK_B3: misaligned_o = 1'b0;
            default:                            misaligned_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/data_bus_bridge.sv
// data_bus_bridge: turns MEM-stage load/store requests into single bus
// transactions, stalling the pipeline until the access completes.
//   clk  rising-edge clock
//   rst  synchronous active-high reset
//   io   data_bus_bridge_if.master (MEM request side and bus side)
// Optional feature: define DATA_BUS_BRIDGE_TIMEOUT_EN to abort a bus access
// after TIMEOUT REQ cycles without bus_ack/bus_err (err=1, rdData=0).
//
// state | meaning
// IDLE  | waiting for memCe with memWr/memRr; request latched on entry to REQ/DONE
// REQ   | bus_req high with latched address/data/mask, waiting for ack/err
// DONE  | one-cycle completion: stall low, rdData and err valid
module data_bus_bridge
    import data_bus_bridge_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEF,
    parameter int WAIT_W  = 8
)
(
    input logic                clk,
    input logic                rst,
    data_bus_bridge_if.master  io
);

    if (TIMEOUT < 1 || TIMEOUT >= (1 << WAIT_W)) begin : g_bad_timeout
        $error("data_bus_bridge: TIMEOUT must be in 1 .. 2**WAIT_W-1");
    end

    state_t      state_q;
    logic [31:0] rd_data_q;
    logic        err_q;
    logic        bus_req_q;
    logic        bus_we_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [3:0]  mask_q;
    logic        conflict_q;
`ifdef DATA_BUS_BRIDGE_TIMEOUT_EN
    logic [WAIT_W-1:0] wait_q;
`endif

    logic       access_req;
    logic [3:0] req_mask;
    logic       misaligned;

    assign access_req = io.memCe & (io.memWr | io.memRr);
    // Simultaneous memWr/memRr is handled as a store, so the store mask wins.
    assign req_mask   = io.memWr ? io.w_mask : io.r_mask;

    bridge_align_chk u_align_chk (
        .addr_i       (io.memAddr[1:0]),
        .mask_i       (req_mask),
        .misaligned_o (misaligned)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            rd_data_q  <= '0;
            err_q      <= 1'b0;
            bus_req_q  <= 1'b0;
            bus_we_q   <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            mask_q     <= '0;
            conflict_q <= 1'b0;
`ifdef DATA_BUS_BRIDGE_TIMEOUT_EN
            wait_q     <= '0;
`endif
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (access_req) begin
                        addr_q     <= io.memAddr;
                        wdata_q    <= io.wtData;
                        mask_q     <= req_mask;
                        bus_we_q   <= io.memWr;
                        conflict_q <= io.memWr & io.memRr;
                        if (misaligned) begin
                            state_q   <= ST_DONE;
                            err_q     <= 1'b1;
                            rd_data_q <= '0;
                        end else begin
                            state_q   <= ST_REQ;
                            bus_req_q <= 1'b1;
`ifdef DATA_BUS_BRIDGE_TIMEOUT_EN
                            wait_q    <= '0;
`endif
                        end
                    end
                end
                ST_REQ: begin
                    if (io.bus_err) begin
                        state_q   <= ST_DONE;
                        bus_req_q <= 1'b0;
                        err_q     <= 1'b1;
                        rd_data_q <= '0;
                    end else if (io.bus_ack) begin
                        state_q   <= ST_DONE;
                        bus_req_q <= 1'b0;
                        err_q     <= conflict_q;
                        rd_data_q <= bus_we_q ? '0 : (io.bus_rdata & lane_expand(mask_q));
                    end
`ifdef DATA_BUS_BRIDGE_TIMEOUT_EN
                    else if (wait_q == WAIT_W'(TIMEOUT - 1)) begin
                        state_q   <= ST_DONE;
                        bus_req_q <= 1'b0;
                        err_q     <= 1'b1;
                        rd_data_q <= '0;
                    end else begin
                        wait_q <= wait_q + 1'b1;
                    end
`endif
                end
                ST_DONE: begin
                    // rdData/err are only meaningful for this single cycle.
                    state_q   <= ST_IDLE;
                    err_q     <= 1'b0;
                    rd_data_q <= '0;
                end
                default: begin
                    state_q   <= ST_IDLE;
                    bus_req_q <= 1'b0;
                    err_q     <= 1'b0;
                end
            endcase
        end
    end

    // The IDLE term must be combinational so the pipeline freezes in the
    // same cycle the request is presented.
    assign io.stall     = (state_q == ST_REQ) |
                          ((state_q == ST_IDLE) & access_req & ~rst);
    assign io.rdData    = rd_data_q;
    assign io.err       = err_q;
    assign io.bus_req   = bus_req_q;
    assign io.bus_we    = bus_we_q;
    assign io.bus_addr  = addr_q;
    assign io.bus_wdata = wdata_q;
    assign io.bus_mask  = mask_q;

endmodule

// File: tb/tb_data_bus_bridge.sv
module tb_data_bus_bridge;

    localparam int TMO = 4;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    data_bus_bridge_if dut_if();

    data_bus_bridge #(.TIMEOUT(TMO), .WAIT_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .io  (dut_if)
    );

    int n_pass  = 0;
    int n_fail  = 0;
    int n_total = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic bit ref_misaligned(input logic [1:0] a, input logic [3:0] m);
        if (m == 4'b1111) return a != 2'b00;
        if (m == 4'b0011 || m == 4'b1100) return a[0];
        if ($countones(m) == 1) return 1'b0;
        return 1'b1;
    endfunction

    function automatic logic [31:0] ref_lanes(input logic [31:0] d, input logic [3:0] m);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < 4; i++) begin
            if (m[i]) r[8*i +: 8] = d[8*i +: 8];
        end
        return r;
    endfunction

    // One complete access: request in IDLE, bus target answers after `delay`
    // REQ cycles (with error if berr), then DONE and return to IDLE.
    task automatic do_access(input string tag, input bit wr, input bit rd,
                             input logic [31:0] addr, input logic [31:0] wdata,
                             input logic [3:0] mask, input int delay,
                             input logic [31:0] rdata, input bit berr);
        bit          mis;
        bit          tmo;
        bit          exp_err;
        int          exp_cycles;
        int          n;
        logic [31:0] exp_rd;

        mis = ref_misaligned(addr[1:0], mask);
        tmo = 1'b0;
`ifdef DATA_BUS_BRIDGE_TIMEOUT_EN
        tmo = !mis && (delay >= TMO);
`endif
        exp_cycles = mis ? 0 : (tmo ? TMO : delay + 1);
        exp_err    = mis | tmo | berr | (wr & rd);
        exp_rd     = (mis || tmo || berr || wr) ? 32'h0 : ref_lanes(rdata, mask);

        @(negedge clk);
        dut_if.memCe   = 1'b1;
        dut_if.memWr   = wr;
        dut_if.memRr   = rd;
        dut_if.memAddr = addr;
        dut_if.wtData  = wdata;
        dut_if.w_mask  = wr ? mask : 4'($urandom);
        dut_if.r_mask  = wr ? 4'($urandom) : mask;
        #1;
        chk({tag, " stall_on_request"}, 32'(dut_if.stall), 32'h1);
        chk({tag, " no_bus_req_in_idle"}, 32'(dut_if.bus_req), 32'h0);

        @(negedge clk);
        // Request inputs change while busy; the latched copy must hold.
        dut_if.memCe   = 1'b1;
        dut_if.memWr   = 1'($urandom);
        dut_if.memRr   = 1'b1;
        dut_if.memAddr = $urandom;
        dut_if.wtData  = $urandom;
        dut_if.w_mask  = 4'($urandom);
        dut_if.r_mask  = 4'($urandom);

        n = 0;
        while (dut_if.bus_req === 1'b1 && n < 300) begin
            chk({tag, " bus_addr"},  dut_if.bus_addr, addr);
            chk({tag, " bus_wdata"}, dut_if.bus_wdata, wdata);
            chk({tag, " bus_mask"},  32'(dut_if.bus_mask), 32'(mask));
            chk({tag, " bus_we"},    32'(dut_if.bus_we), 32'(wr));
            chk({tag, " stall_req"}, 32'(dut_if.stall), 32'h1);
            dut_if.bus_err   = (n == delay) && berr;
            dut_if.bus_ack   = (n == delay) && (!berr || ($urandom_range(0, 1) == 1));
            dut_if.bus_rdata = (n == delay) ? rdata : $urandom;
            @(negedge clk);
            n++;
            dut_if.bus_ack = 1'b0;
            dut_if.bus_err = 1'b0;
        end

        chk({tag, " req_cycles"},  32'(n), 32'(exp_cycles));
        chk({tag, " stall_done"},  32'(dut_if.stall), 32'h0);
        chk({tag, " err_done"},    32'(dut_if.err), 32'(exp_err));
        chk({tag, " rdData_done"}, dut_if.rdData, exp_rd);

        @(negedge clk);
        dut_if.memCe = 1'b0;
        dut_if.memWr = 1'b0;
        dut_if.memRr = 1'b0;
        #1;
        chk({tag, " idle_stall"},   32'(dut_if.stall), 32'h0);
        chk({tag, " idle_err"},     32'(dut_if.err), 32'h0);
        chk({tag, " idle_bus_req"}, 32'(dut_if.bus_req), 32'h0);
        chk({tag, " idle_rdData"},  dut_if.rdData, 32'h0);
    endtask

    logic [3:0] mlist [10] = '{4'b1111, 4'b0011, 4'b1100, 4'b0001, 4'b0010,
                               4'b0100, 4'b1000, 4'b0110, 4'b0101, 4'b0000};

    initial begin
        rst              = 1'b1;
        dut_if.memCe     = 1'b0;
        dut_if.memWr     = 1'b0;
        dut_if.memRr     = 1'b0;
        dut_if.memAddr   = '0;
        dut_if.wtData    = '0;
        dut_if.w_mask    = '0;
        dut_if.r_mask    = '0;
        dut_if.bus_ack   = 1'b0;
        dut_if.bus_err   = 1'b0;
        dut_if.bus_rdata = '0;
        repeat (3) @(negedge clk);

        chk("rst stall",     32'(dut_if.stall), 32'h0);
        chk("rst err",       32'(dut_if.err), 32'h0);
        chk("rst bus_req",   32'(dut_if.bus_req), 32'h0);
        chk("rst bus_we",    32'(dut_if.bus_we), 32'h0);
        chk("rst rdData",    dut_if.rdData, 32'h0);
        chk("rst bus_addr",  dut_if.bus_addr, 32'h0);
        chk("rst bus_wdata", dut_if.bus_wdata, 32'h0);
        chk("rst bus_mask",  32'(dut_if.bus_mask), 32'h0);
        rst = 1'b0;

        // No-request cases stay idle.
        @(negedge clk);
        dut_if.memCe = 1'b1;
        #1;
        chk("ce_only stall", 32'(dut_if.stall), 32'h0);
        @(negedge clk);
        chk("ce_only bus_req", 32'(dut_if.bus_req), 32'h0);
        dut_if.memCe = 1'b0;
        dut_if.memRr = 1'b1;
        #1;
        chk("rr_no_ce stall", 32'(dut_if.stall), 32'h0);
        @(negedge clk);
        chk("rr_no_ce bus_req", 32'(dut_if.bus_req), 32'h0);
        dut_if.memRr = 1'b0;

        do_access("load_word",   1'b0, 1'b1, 32'h10, 32'h0, 4'b1111, 0, 32'hDEADBEEF, 1'b0);
        do_access("store_half",  1'b1, 1'b0, 32'h22, 32'hABCD0000, 4'b1100, 5, 32'h0, 1'b0);
        do_access("misaligned",  1'b0, 1'b1, 32'h13, 32'h0, 4'b1111, 0, 32'h12345678, 1'b0);
        do_access("load_byte1",  1'b0, 1'b1, 32'h21, 32'h0, 4'b0010, 1, 32'h11223344, 1'b0);
        do_access("half_odd",    1'b1, 1'b0, 32'h41, 32'h5555AAAA, 4'b0011, 0, 32'h0, 1'b0);
        do_access("bad_mask",    1'b0, 1'b1, 32'h40, 32'h0, 4'b0110, 0, 32'hFFFFFFFF, 1'b0);
        do_access("wr_and_rd",   1'b1, 1'b1, 32'h80, 32'h01020304, 4'b1111, 1, 32'hCAFEF00D, 1'b0);
        do_access("bus_error",   1'b0, 1'b1, 32'h90, 32'h0, 4'b1111, 2, 32'hA5A5A5A5, 1'b1);
        do_access("load_half_h", 1'b0, 1'b1, 32'hA2, 32'h0, 4'b1100, 3, 32'h87654321, 1'b0);
        // Long wait: aborts under the timeout build, otherwise REQ persists.
        do_access("long_wait",   1'b0, 1'b1, 32'hB0, 32'h0, 4'b1111, 105, 32'h0BADF00D, 1'b0);

        // Reset during the second REQ cycle.
        @(negedge clk);
        dut_if.memCe   = 1'b1;
        dut_if.memRr   = 1'b1;
        dut_if.memAddr = 32'h30;
        dut_if.r_mask  = 4'b1111;
        @(negedge clk);
        dut_if.memCe = 1'b0;
        dut_if.memRr = 1'b0;
        chk("mid_rst req1", 32'(dut_if.bus_req), 32'h1);
        @(negedge clk);
        chk("mid_rst req2", 32'(dut_if.bus_req), 32'h1);
        rst = 1'b1;
        dut_if.bus_ack   = 1'b1;
        dut_if.bus_rdata = 32'h77777777;
        @(negedge clk);
        rst            = 1'b0;
        dut_if.bus_ack = 1'b0;
        #1;
        chk("mid_rst bus_req", 32'(dut_if.bus_req), 32'h0);
        chk("mid_rst stall",   32'(dut_if.stall), 32'h0);
        chk("mid_rst err",     32'(dut_if.err), 32'h0);
        chk("mid_rst rdData",  dut_if.rdData, 32'h0);
        do_access("after_rst", 1'b0, 1'b1, 32'h34, 32'h0, 4'b1111, 0, 32'h13572468, 1'b0);

        for (int k = 0; k < 40; k++) begin
            int          sel;
            bit          wr;
            bit          rd;
            logic [3:0]  m;
            sel = $urandom_range(0, 7);
            wr  = (sel >= 4);
            rd  = (sel < 4) || (sel == 7);
            m   = mlist[$urandom_range(0, 9)];
            do_access("random", wr, rd, $urandom, $urandom, m,
                      $urandom_range(0, 6), $urandom, ($urandom_range(0, 7) == 0));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
